// File: rtl/wfg_capture_spi.sv
// SPI slave receiver: synchronizes an external SPI bus into io_wbs_clk, assembles
// 8/16/24/32-bit words in any SPI mode and queues them in a small receive FIFO.
module wfg_capture_spi #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         io_wbs_clk,
    input  logic                         io_wbs_rst,
    input  logic                         cfg_en_i,
    input  logic                         cfg_cpol_i,
    input  logic                         cfg_cpha_i,
    input  logic                         cfg_lsbfirst_i,
    input  logic [1:0]                   cfg_dff_i,
    input  logic                         clr_i,
    input  logic                         spi_sclk_i,
    input  logic                         spi_cs_ni,
    input  logic                         spi_sdi_i,
    output logic [31:0]                  rx_data_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]  rx_level_o,
    output logic                         overflow_o,
    output logic                         frame_err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t       r_state, w_state_nxt;
    logic         r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic         r_cs_s1, r_cs_s2;
    logic         r_sdi_s1, r_sdi_s2;
    logic [1:0]   r_warm;
    logic         r_armed;
    logic [4:0]   r_bit_cnt;
    logic [31:0]  r_shift, w_shift_nxt;
    logic [31:0]  r_mem [FIFO_DEPTH];
    logic [AW:0]  r_wr_ptr, r_rd_ptr;
    logic         w_sample, w_last, w_start, w_capture, w_push, w_frame_err;
    logic         w_full, w_pop, w_wr_en, w_overflow;

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            r_sclk_s1 <= cfg_cpol_i;
            r_sclk_s2 <= cfg_cpol_i;
            r_sclk_d  <= cfg_cpol_i;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_sdi_s1  <= 1'b0;
            r_sdi_s2  <= 1'b0;
        end else begin
            r_sclk_s1 <= spi_sclk_i;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_cs_s1   <= spi_cs_ni;
            r_cs_s2   <= r_cs_s1;
            r_sdi_s1  <= spi_sdi_i;
            r_sdi_s2  <= r_sdi_s1;
        end
    end

    // Capture is armed only once a real CS-high has flushed through the synchronizer,
    // so a reset in the middle of a frame never resumes on the tail of that frame.
    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            r_warm  <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
            if (r_warm == 2'd2 && r_cs_s2) r_armed <= 1'b1;
        end
    end

    assign w_sample = (cfg_cpol_i ^ cfg_cpha_i) ? (~r_sclk_s2 & r_sclk_d)
                                                : (r_sclk_s2 & ~r_sclk_d);
    assign w_last   = (r_bit_cnt == {cfg_dff_i, 3'b111});

    always_comb begin
        // NOTE: blocking assignments in combinational logic, and every output gets a
        // default first so no path leaves a signal unassigned (which would infer a latch).
        w_shift_nxt = r_shift;
        if (cfg_lsbfirst_i) w_shift_nxt[r_bit_cnt] = r_sdi_s2;
        else                w_shift_nxt = {r_shift[30:0], r_sdi_s2};
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        if (!cfg_en_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_cs_s2 && r_armed) begin
                        w_state_nxt = ST_ACTIVE;
                        w_start     = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (r_cs_s2) begin
                        w_state_nxt = ST_IDLE;
                        w_frame_err = (r_bit_cnt != 5'd0);
                    end else if (w_sample) begin
                        w_capture = 1'b1;
                        w_push    = w_last;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst || w_start) begin
            r_bit_cnt <= 5'd0;
            r_shift   <= 32'd0;
        end else if (w_capture) begin
            // Clearing after a push keeps MSB-first words right-justified.
            r_bit_cnt <= w_last ? 5'd0 : r_bit_cnt + 5'd1;
            r_shift   <= w_last ? 32'd0 : w_shift_nxt;
        end
    end

    assign rx_valid_o = (r_wr_ptr != r_rd_ptr);
    assign rx_level_o = r_wr_ptr - r_rd_ptr;
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = rx_ready_i && rx_valid_o;
    assign w_wr_en    = w_push && (!w_full || w_pop);
    assign w_overflow = w_push && w_full && !w_pop;
    assign rx_data_o  = rx_valid_o ? r_mem[r_rd_ptr[AW-1:0]] : 32'd0;

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst || !cfg_en_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers define validity and rx_data_o is gated.
    always_ff @(posedge io_wbs_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_shift_nxt;
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (w_overflow)  overflow_o <= 1'b1;
            else if (clr_i)  overflow_o <= 1'b0;
            if (w_frame_err) frame_err_o <= 1'b1;
            else if (clr_i)  frame_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wfg_capture_spi.sv
// Directed bench for wfg_capture_spi: table of single-word frames in all modes,
// plus hand-written latency, overflow, push/pop, frame error, flush and reset cases.
module tb_wfg_capture_spi;

    localparam int DEPTH = 4;
    localparam int H     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1, cpol = 1'b0, cpha = 1'b0, lsb = 1'b0, clr = 1'b0;
    logic [1:0]  dff = 2'd0;
    logic        sclk = 1'b0, cs_n = 1'b1, sdi = 1'b0, ready = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid, ovf, ferr;
    logic [$clog2(DEPTH):0] level;

    int n_checks = 0;
    int n_fail   = 0;

    wfg_capture_spi #(.FIFO_DEPTH(DEPTH)) dut (
        .io_wbs_clk    (clk),
        .io_wbs_rst    (rst),
        .cfg_en_i      (en),
        .cfg_cpol_i    (cpol),
        .cfg_cpha_i    (cpha),
        .cfg_lsbfirst_i(lsb),
        .cfg_dff_i     (dff),
        .clr_i         (clr),
        .spi_sclk_i    (sclk),
        .spi_cs_ni     (cs_n),
        .spi_sdi_i     (sdi),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (ready),
        .rx_level_o    (level),
        .overflow_o    (ovf),
        .frame_err_o   (ferr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic        lsb;
        logic [1:0]  dff;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (!cpha) begin
            sdi = b;
            hold(H);
            sclk = ~cpol;
            hold(H);
            sclk = cpol;
        end else begin
            sclk = ~cpol;
            sdi  = b;
            hold(H);
            sclk = cpol;
            hold(H);
        end
    endtask

    task automatic send_word(input logic [31:0] data);
        int w;
        w = 8 * (int'(dff) + 1);
        for (int i = 0; i < w; i++) send_bit(lsb ? data[i] : data[w-1-i]);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        hold(H);
    endtask

    task automatic cs_end();
        hold(H);
        cs_n = 1'b1;
        hold(12);
    endtask

    task automatic setup(input logic p, input logic h, input logic l, input logic [1:0] d);
        cpol = p; cpha = h; lsb = l; dff = d;
        sclk = p;
        hold(10);
    endtask

    task automatic pop_check(input string name, input logic [31:0] exp);
        check(name, rx_data, exp);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    vec_t        vecs[7];
    logic [31:0] words[5];
    logic [7:0]  bytes[5];
    logic [7:0]  lat_byte;
    logic [31:0] coffee;

    initial begin
        vecs = '{
            '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_00A5, 32'h0000_00A5},
            '{1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_1234, 32'h0000_1234},
            '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_1234, 32'h0000_1234},
            '{1'b1, 1'b0, 1'b1, 2'd1, 32'hFFFF_1234, 32'h0000_1234},
            '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_00B4, 32'h0000_00B4},
            '{1'b0, 1'b1, 1'b0, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
            '{1'b1, 1'b1, 1'b0, 2'd2, 32'h00C0_FFEE, 32'h00C0_FFEE}
        };
        words    = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h5A5A_5A5A};
        bytes    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        lat_byte = 8'h3C;
        coffee   = 32'h00C0_FFEE;

        hold(3);
        rst = 1'b0;
        hold(1);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_data", rx_data, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        hold(6);

        for (int v = 0; v < 7; v++) begin
            setup(vecs[v].cpol, vecs[v].cpha, vecs[v].lsb, vecs[v].dff);
            cs_start();
            send_word(vecs[v].data);
            cs_end();
            check($sformatf("vec%0d_level", v), 32'(level), 32'd1);
            check($sformatf("vec%0d_ovf", v), {31'd0, ovf}, 32'd0);
            check($sformatf("vec%0d_ferr", v), {31'd0, ferr}, 32'd0);
            pop_check($sformatf("vec%0d_data", v), vecs[v].exp);
            check($sformatf("vec%0d_empty", v), {31'd0, rx_valid}, 32'd0);
        end

        // Latency: final sample edge to rx_valid_o is three clock edges.
        setup(1'b0, 1'b0, 1'b0, 2'd0);
        cs_start();
        for (int i = 0; i < 7; i++) send_bit(lat_byte[7-i]);
        sdi = lat_byte[0];
        hold(H);
        sclk = 1'b1;
        hold(1);
        check("lat_edge1", {31'd0, rx_valid}, 32'd0);
        hold(1);
        check("lat_edge2", {31'd0, rx_valid}, 32'd0);
        hold(1);
        check("lat_edge3", {31'd0, rx_valid}, 32'd1);
        hold(H - 3);
        sclk = 1'b0;
        cs_end();
        pop_check("lat_data", 32'h0000_003C);

        // Five 32-bit words into a 4-deep FIFO with no consumer.
        setup(1'b0, 1'b0, 1'b0, 2'd3);
        cs_start();
        for (int k = 0; k < 5; k++) send_word(words[k]);
        cs_end();
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        check("ovf_ferr", {31'd0, ferr}, 32'd0);
        for (int k = 0; k < 4; k++) pop_check($sformatf("ovf_pop%0d", k), words[k]);
        check("ovf_drained", 32'(level), 32'd0);
        pulse_clr();
        check("ovf_clr", {31'd0, ovf}, 32'd0);

        // Full FIFO, pop lands on the same edge as the fifth push.
        setup(1'b0, 1'b0, 1'b0, 2'd0);
        cs_start();
        for (int k = 0; k < 4; k++) send_word({24'd0, bytes[k]});
        check("pp_full", 32'(level), 32'd4);
        for (int i = 0; i < 7; i++) send_bit(bytes[4][7-i]);
        sdi = bytes[4][0];
        hold(H);
        sclk = 1'b1;
        hold(2);
        ready = 1'b1;
        hold(1);
        ready = 1'b0;
        check("pp_level", 32'(level), 32'd4);
        check("pp_ovf", {31'd0, ovf}, 32'd0);
        hold(H - 3);
        sclk = 1'b0;
        cs_end();
        for (int k = 1; k < 5; k++) pop_check($sformatf("pp_pop%0d", k), {24'd0, bytes[k]});
        check("pp_drained", 32'(level), 32'd0);

        // CS raised after 5 of 8 bits.
        setup(1'b0, 1'b0, 1'b0, 2'd0);
        cs_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        cs_end();
        check("fe_flag", {31'd0, ferr}, 32'd1);
        check("fe_level", 32'(level), 32'd0);
        check("fe_ovf", {31'd0, ovf}, 32'd0);
        pulse_clr();
        check("fe_clr", {31'd0, ferr}, 32'd0);

        // Disabling flushes a non-empty FIFO.
        cs_start();
        send_word(32'h0000_005A);
        cs_end();
        check("flush_pre", 32'(level), 32'd1);
        en = 1'b0;
        hold(1);
        check("flush_level", 32'(level), 32'd0);
        check("flush_valid", {31'd0, rx_valid}, 32'd0);
        en = 1'b1;
        hold(4);

        // Reset after 12 of 24 bits; the frame tail must be ignored.
        setup(1'b0, 1'b0, 1'b0, 2'd2);
        cs_start();
        for (int i = 0; i < 12; i++) send_bit(coffee[23-i]);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        for (int i = 12; i < 24; i++) send_bit(coffee[23-i]);
        cs_end();
        check("rmf_level", 32'(level), 32'd0);
        check("rmf_ovf", {31'd0, ovf}, 32'd0);
        check("rmf_ferr", {31'd0, ferr}, 32'd0);
        hold(4);
        cs_start();
        send_word(coffee);
        cs_end();
        check("rmf_next_level", 32'(level), 32'd1);
        check("rmf_next_ferr", {31'd0, ferr}, 32'd0);
        pop_check("rmf_next_data", 32'h00C0_FFEE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wfg_capture_spi.md
WFG_CAPTURE_SPI -- requirements
Module: wfg_capture_spi

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, receive FIFO depth in words (power of two, >=2).
REQ-002 The block SHALL have port io_wbs_clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port io_wbs_rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port cfg_en_i, input, 1, capture enable.
REQ-005 The block SHALL have port cfg_cpol_i, input, 1, SCLK idle level.
REQ-006 The block SHALL have port cfg_cpha_i, input, 1, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-007 The block SHALL have port cfg_lsbfirst_i, input, 1, 1 = first received bit is word bit 0.
REQ-008 The block SHALL have port cfg_dff_i, input, 2, word width: 0/1/2/3 = 8/16/24/32 bits.
REQ-009 The block SHALL have port clr_i, input, 1, one-cycle pulse that clears the sticky error flags.
REQ-010 The block SHALL have port spi_sclk_i, input, 1, asynchronous SPI clock from the driver side.
REQ-011 The block SHALL have port spi_cs_ni, input, 1, asynchronous active-low chip select.
REQ-012 The block SHALL have port spi_sdi_i, input, 1, asynchronous serial data.
REQ-013 The block SHALL have port rx_data_o, output, 32, head FIFO word, right-justified, unused upper bits 0.
REQ-014 The block SHALL have port rx_valid_o, output, 1, FIFO not empty.
REQ-015 The block SHALL have port rx_ready_i, input, 1, consumer pops the head word when high together with rx_valid_o.
REQ-016 The block SHALL have port rx_level_o, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-017 The block SHALL have port overflow_o, output, 1, sticky: completed word dropped because FIFO full.
REQ-018 The block SHALL have port frame_err_o, output, 1, sticky: CS deasserted mid-word.

Function
REQ-019 spi_sclk_i, spi_cs_ni and spi_sdi_i SHALL each pass through a 2-flop synchronizer; all further logic uses synchronized copies only.
REQ-020 Edge detection SHALL compare synchronized SCLK with a third registered copy; sample edge = rising when cpol XOR cpha = 0, falling otherwise.
REQ-021 Supported SCLK frequency SHALL be at most io_wbs_clk/4; faster SCLK is out of scope.
REQ-022 FSM states SHALL be IDLE and ACTIVE only.
REQ-023 IDLE -> ACTIVE on synchronized CS low while cfg_en_i = 1; entry clears bit counter and shift register.
REQ-024 In ACTIVE each sample edge SHALL capture synchronized SDI: MSB-first shifts left with new bit at LSB; LSB-first writes bit at position bit_cnt.
REQ-025 When the captured bit is bit number W-1 (W = 8*(cfg_dff_i+1)), the completed word including that bit SHALL be pushed in the same cycle, bit counter returns to 0, state stays ACTIVE (back-to-back words per frame).
REQ-026 ACTIVE -> IDLE on synchronized CS high; if bit counter != 0 the partial word is discarded and frame_err_o set.
REQ-027 Push with FIFO full and no simultaneous pop SHALL drop the word and set overflow_o; push and pop in the same cycle when full SHALL both succeed.
REQ-028 Latency: rx_valid_o SHALL rise 3 io_wbs_clk edges after the final sample edge is stable on spi_sclk_i (2 sync + 1 detect/push).
REQ-029 Pop when empty SHALL have no effect; rx_data_o is don't-care when rx_valid_o = 0.
REQ-030 cfg_en_i = 0 SHALL force IDLE and flush the FIFO in that cycle; config inputs are static while CS is low.
REQ-031 clr_i SHALL clear overflow_o and frame_err_o; a same-cycle new error SHALL win (flag stays 1).

Reset
REQ-032 io_wbs_rst SHALL, on the next clock edge, force IDLE, clear synchronizers to CS high / SCLK = cfg_cpol_i / SDI 0, empty FIFO, and drive rx_valid_o = 0, rx_level_o = 0, rx_data_o = 0, overflow_o = 0, frame_err_o = 0.
REQ-033 Reset mid-frame SHALL discard the partial word without setting frame_err_o; capture resumes only after CS is seen high then low.

Verification
REQ-034 Mode 0, MSB-first, 8-bit, send 0xA5 in one frame -> one word 0x000000A5, rx_level_o = 1, no flags.
REQ-035 Mode 3, LSB-first, 16-bit, send bits of 0x1234 LSB first -> 0x00001234; mode 1 and mode 2 repeated with same result.
REQ-036 32-bit, one frame of 5 words, rx_ready_i = 0, FIFO_DEPTH 4 -> level 4, overflow_o = 1, popped words are first four in order.
REQ-037 8-bit, CS raised after 5 bits -> frame_err_o = 1, no push; clr_i pulse -> flag 0.
REQ-038 FIFO full with rx_ready_i = 1 on cycle of a new push -> level stays 4, overflow_o = 0.
REQ-039 io_wbs_rst asserted after 12 of 24 bits then frame continues -> no word, no flags; next frame of 0xC0FFEE captured correctly.
